// File: rtl/pixel_stream_pkg.sv
// rtl/pixel_stream_pkg.sv - shared state encoding and frame header constants
package pixel_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        FETCH,
        LATCH,
        SEND_HI,
        SEND_LO,
        DONE
    } state_t;

    localparam logic [7:0] HDR_BYTE0 = 8'hAA;
    localparam logic [7:0] HDR_BYTE1 = 8'h55;

endpackage

// File: rtl/pixel_stream_reader_if.sv
// rtl/pixel_stream_reader_if.sv - frame-buffer read port plus UART byte handshake
interface pixel_stream_reader_if #(
    parameter int ADDR_W  = 17,
    parameter int PIXEL_W = 12,
    parameter int BITS_N  = 8
);

    logic [ADDR_W-1:0]  rd_addr;
    logic [PIXEL_W-1:0] rd_data;
    logic [BITS_N-1:0]  tx_data;
    logic               tx_valid;
    logic               tx_ready;

    // Reader side: issues addresses and offers bytes
    modport master (
        output rd_addr,
        input  rd_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Memory/UART side: returns pixels and accepts bytes
    modport slave (
        input  rd_addr,
        output rd_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/pixel_stream_reader.sv
// rtl/pixel_stream_reader.sv - streams one frame buffer as header plus hi/lo pixel bytes
module pixel_stream_reader
    import pixel_stream_pkg::*;
#(
    parameter int IMAGE_SIZE = 76800,
    parameter int ADDR_W     = 17,
    parameter int PIXEL_W    = 12,
    parameter int BITS_N     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    pixel_stream_reader_if.master  bus,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(IMAGE_SIZE - 1);

    state_t             state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic [PIXEL_W-1:0] pix_q;
    logic               xfer;

    // Upper pixel bits, zero padded to a full byte
    function automatic logic [BITS_N-1:0] hi_byte(input logic [PIXEL_W-1:0] p);
        logic [15:0] ext;
        ext = 16'(p);
        return BITS_N'(ext[15:8]);
    endfunction

    function automatic logic [BITS_N-1:0] lo_byte(input logic [PIXEL_W-1:0] p);
        return BITS_N'(p[7:0]);
    endfunction

    assign xfer = bus.tx_valid && bus.tx_ready;

    // Frame sequencer: all outputs are registered so the UART sees glitch-free data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pix_q        <= '0;
            bus.rd_addr  <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= HDR0;
                        cnt_q        <= '0;
                        busy         <= 1'b1;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= BITS_N'(HDR_BYTE0);
                    end
                end
                HDR0: begin
                    if (xfer) begin
                        state_q     <= HDR1;
                        bus.tx_data <= BITS_N'(HDR_BYTE1);
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        state_q      <= FETCH;
                        bus.tx_valid <= 1'b0;
                        bus.rd_addr  <= cnt_q;
                    end
                end
                FETCH: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    // Read data arrives now; the high byte goes out straight from it
                    state_q      <= SEND_HI;
                    pix_q        <= bus.rd_data;
                    bus.tx_data  <= hi_byte(bus.rd_data);
                    bus.tx_valid <= 1'b1;
                end
                SEND_HI: begin
                    if (xfer) begin
                        state_q     <= SEND_LO;
                        bus.tx_data <= lo_byte(pix_q);
                    end else begin
                        // Stalled: keep offering the same high byte
                        bus.tx_data <= hi_byte(pix_q);
                    end
                end
                SEND_LO: begin
                    if (xfer) begin
                        bus.tx_valid <= 1'b0;
                        if (cnt_q == LAST_PIXEL) begin
                            state_q <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q     <= FETCH;
                            cnt_q       <= cnt_q + ADDR_W'(1);
                            bus.rd_addr <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_reader.sv
// tb/tb_pixel_stream_reader.sv - directed self-checking bench for pixel_stream_reader
module tb_pixel_stream_reader;

    localparam int IMAGE_SIZE = 4;
    localparam int ADDR_W     = 17;
    localparam int PIXEL_W    = 12;
    localparam int BITS_N     = 8;
    localparam int FRAME_LEN  = 2 + 2 * IMAGE_SIZE;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    pixel_stream_reader_if #(.ADDR_W(ADDR_W), .PIXEL_W(PIXEL_W), .BITS_N(BITS_N)) bus ();

    pixel_stream_reader #(
        .IMAGE_SIZE (IMAGE_SIZE),
        .ADDR_W     (ADDR_W),
        .PIXEL_W    (PIXEL_W),
        .BITS_N     (BITS_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    int checks = 0;
    int errors = 0;

    logic       rand_en;
    logic       ready_val;
    logic [7:0] log_q[$];
    int         done_cnt     = 0;
    int         busy_low_cnt = 0;
    int         stab_err     = 0;
    logic       hold_pend    = 1'b0;
    logic [7:0] hold_data    = '0;
    logic [ADDR_W-1:0] rd_max = '0;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Frame buffer model: 1-cycle read latency, pixel = 0xA00 + address
    always @(posedge clk) bus.rd_data <= 12'hA00 + 12'(bus.rd_addr);

    // UART ready: fixed level or random backpressure
    always @(posedge clk) begin
        #1;
        bus.tx_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Observer sampling mid-cycle
    always @(negedge clk) begin
        if (rst_n && bus.tx_valid && bus.tx_ready) log_q.push_back(bus.tx_data);
        if (hold_pend && rst_n && (!bus.tx_valid || bus.tx_data != hold_data)) stab_err++;
        hold_pend = rst_n && bus.tx_valid && !bus.tx_ready;
        hold_data = bus.tx_data;
        if (done) done_cnt++;
        if (!busy) busy_low_cnt++;
        if (bus.rd_addr > rd_max) rd_max = bus.rd_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [11:0] px;
        if (i == 0) return 8'hAA;
        if (i == 1) return 8'h55;
        px = 12'hA00 + 12'((i - 2) / 2);
        if (((i - 2) % 2) == 0) return {4'h0, px[11:8]};
        return px[7:0];
    endfunction

    task automatic check_frame(input string tag, input int base);
        logic [31:0] got;
        for (int i = 0; i < FRAME_LEN; i++) begin
            got = (base + i < log_q.size()) ? 32'(log_q[base + i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_b%0d", tag, i), got, 32'(exp_byte(i)));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  base;
        int  d0;
        int  b0;

        rst_n     = 1'b0;
        start     = 1'b0;
        rand_en   = 1'b0;
        ready_val = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_data",  32'(bus.tx_data),  32'd0);
        check("rst_addr",  32'(bus.rd_addr),  32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_done",  32'(done),         32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single frame, no backpressure; 19 cycles incl. 2 idle cycles per pixel
        base = log_q.size();
        d0   = done_cnt;
        pulse_start();
        check("t1_busy_set", 32'(busy), 32'd1);
        wait_done(2000, cyc, ok);
        check("t1_done_seen", 32'(ok), 32'd1);
        check("t1_latency", 32'(cyc), 32'd19);
        @(posedge clk);
        #1;
        check("t1_busy_clr", 32'(busy), 32'd0);
        check("t1_done_clr", 32'(done), 32'd0);
        check("t1_count", 32'(log_q.size() - base), 32'(FRAME_LEN));
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_frame("t1", base);

        // Random backpressure
        repeat (3) @(posedge clk);
        base    = log_q.size();
        rand_en = 1'b1;
        pulse_start();
        wait_done(2000, cyc, ok);
        check("t2_done_seen", 32'(ok), 32'd1);
        rand_en = 1'b0;
        repeat (2) @(posedge clk);
        check("t2_count", 32'(log_q.size() - base), 32'(FRAME_LEN));
        check("t2_stable", 32'(stab_err), 32'd0);
        check_frame("t2", base);

        // start re-pulsed during SEND_LO (cycle 6) and during DONE (cycle 19)
        repeat (3) @(posedge clk);
        base = log_q.size();
        d0   = done_cnt;
        pulse_start();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t3_count", 32'(log_q.size() - base), 32'(FRAME_LEN));
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t3_busy_idle", 32'(busy), 32'd0);
        check_frame("t3", base);

        // Reset after the 5th transfer aborts the frame
        base = log_q.size();
        d0   = done_cnt;
        pulse_start();
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t4_valid", 32'(bus.tx_valid), 32'd0);
        check("t4_busy",  32'(busy),         32'd0);
        check("t4_addr",  32'(bus.rd_addr),  32'd0);
        check("t4_data",  32'(bus.tx_data),  32'd0);
        repeat (20) @(posedge clk);
        check("t4_partial", 32'(log_q.size() - base), 32'd5);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        base = log_q.size();
        pulse_start();
        wait_done(2000, cyc, ok);
        check("t4_done_seen", 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        check("t4_count", 32'(log_q.size() - base), 32'(FRAME_LEN));
        check_frame("t4", base);

        // Back-to-back frames, second start in the cycle after DONE
        repeat (3) @(posedge clk);
        base = log_q.size();
        d0   = done_cnt;
        pulse_start();
        b0 = busy_low_cnt;
        wait_done(2000, cyc, ok);
        check("t5_done1_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(2000, cyc, ok);
        check("t5_done2_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        check("t5_busy_low", 32'(busy_low_cnt - b0), 32'd3);
        check("t5_count", 32'(log_q.size() - base), 32'(2 * FRAME_LEN));
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("t5_rd_max", 32'(rd_max), 32'(IMAGE_SIZE - 1));
        check_frame("t5a", base);
        check_frame("t5b", base + FRAME_LEN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_stream_reader.md
PIXEL_STREAM_READER -- requirements
Module: pixel_stream_reader

Interface
REQ-001 Parameter IMAGE_SIZE, default 76800, number of pixels per frame (320x240).
REQ-002 Parameter ADDR_W, default 17, frame-buffer address width; SHALL satisfy 2**ADDR_W >= IMAGE_SIZE.
REQ-003 Parameter PIXEL_W, default 12, frame-buffer pixel width; SHALL be in range 9..16.
REQ-004 Parameter BITS_N, default 8, byte width delivered to the UART transmitter.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 start  input  1  single-cycle frame-send request.
REQ-008 rd_addr  output  ADDR_W  frame-buffer read address.
REQ-009 rd_data  input  PIXEL_W  frame-buffer read data, valid exactly 1 cycle after rd_addr.
REQ-010 tx_data  output  BITS_N  byte offered to the UART transmitter.
REQ-011 tx_valid  output  1  tx_data holds a byte to transfer.
REQ-012 tx_ready  input  1  UART transmitter accepts tx_data this cycle.
REQ-013 busy  output  1  high from the cycle after an accepted start until done.
REQ-014 done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-015 A byte transfer SHALL occur on a rising edge where tx_valid and tx_ready are both 1.
REQ-016 While tx_valid=1 and tx_ready=0, tx_data SHALL remain stable and tx_valid SHALL stay high.
REQ-017 The frame SHALL be sent as: header 0xAA, header 0x55, then for pixel 0..IMAGE_SIZE-1 a high byte {zero pad, pixel[PIXEL_W-1:8]} followed by a low byte pixel[7:0].
REQ-018 The total number of transfers per frame SHALL be 2 + 2*IMAGE_SIZE.
REQ-019 The FSM states SHALL be IDLE, HDR0, HDR1, FETCH, LATCH, SEND_HI, SEND_LO, DONE.
REQ-020 In IDLE with start=1, the block SHALL go to HDR0, clear the pixel counter, and set busy on the next cycle.
REQ-021 HDR0 and HDR1 SHALL present 0xAA and 0x55 respectively and advance on transfer.
REQ-022 FETCH SHALL drive rd_addr=pixel counter for one cycle; LATCH SHALL register rd_data into a pixel register.
REQ-023 SEND_HI SHALL advance to SEND_LO on transfer.
REQ-024 SEND_LO on transfer SHALL go to FETCH with the counter incremented, or to DONE if the counter equals IMAGE_SIZE-1.
REQ-025 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-026 tx_valid SHALL be 1 only in HDR0, HDR1, SEND_HI and SEND_LO.
REQ-027 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-028 A start that arrives in the cycle after DONE SHALL begin a new frame normally.
REQ-029 The pixel counter SHALL never exceed IMAGE_SIZE-1; rd_addr SHALL never reach IMAGE_SIZE.
REQ-030 With tx_ready held at 1, the inter-pixel overhead SHALL be exactly 2 idle cycles (FETCH, LATCH).

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL enter IDLE with tx_valid=0, tx_data=0, rd_addr=0, busy=0, done=0, counter=0 and pixel register=0.
REQ-032 Reset mid-frame SHALL abort the frame with no further transfers, and SHALL not pulse done.

Structure
REQ-033 Package pixel_stream_pkg SHALL hold the state enum and the header constants HDR_BYTE0=8'hAA and HDR_BYTE1=8'h55.
REQ-034 The block SHALL be a single FSM module with no sub-modules.
REQ-035 The block SHALL connect directly to the existing UART transmitter's valid/ready data input.

Verification (IMAGE_SIZE=4, RAM model returns 12'hA00+addr with 1-cycle latency)
REQ-036 rst_n release, start pulse, tx_ready=1 -> bytes AA 55 0A 00 0A 01 0A 02 0A 03; done one pulse; 10 transfers total.
REQ-037 Random tx_ready backpressure -> same 10-byte sequence; tx_data stable whenever valid=1 and ready=0.
REQ-038 start re-pulsed during SEND_LO and during DONE -> ignored; exactly one frame sent.
REQ-039 rst_n=0 after 5th transfer -> tx_valid=0 next cycle, no done pulse; a following start sends a full fresh frame from AA.
REQ-040 Two back-to-back frames (start one cycle after done) -> 20 transfers; rd_addr max observed = 3; busy low only between frames.
